// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: x/y counters, per-axis phase FSMs, registered controls.
// Optional macro VGA_TIMING_OUT_DLY_EN delays the control outputs one pix_en cycle behind x/y.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned CNT_W      = 10
) (
    input  logic             pix_clk,
    input  logic             reset,
    input  logic             pix_en,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] HLast = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VLast = CNT_W'(V_TOTAL - 1);
    localparam bit VBlankRst = (V_FP + V_SYNC + V_BP) != 0;

    typedef enum logic [1:0] {
        PhActive,
        PhFp,
        PhSync,
        PhBp
    } phase_e;

    // Phase entered when the axis counter lands on pos; zero-length phases fall through.
    function automatic phase_e phase_step(input logic [CNT_W-1:0] pos, input phase_e cur,
                                          input int unsigned act, input int unsigned fp,
                                          input int unsigned sync);
        if (pos == '0) begin
            return PhActive;
        end
        if (pos == CNT_W'(act)) begin
            if (fp != 0) return PhFp;
            if (sync != 0) return PhSync;
            return PhBp;
        end
        if (pos == CNT_W'(act + fp)) begin
            if (sync != 0) return PhSync;
            return PhBp;
        end
        if (pos == CNT_W'(act + fp + sync)) begin
            return PhBp;
        end
        return cur;
    endfunction

    // Phase that owns the last position of an axis, used as the reset phase.
    function automatic phase_e phase_last(input int unsigned fp, input int unsigned sync,
                                          input int unsigned bp);
        if (bp != 0) return PhBp;
        if (sync != 0) return PhSync;
        if (fp != 0) return PhFp;
        return PhActive;
    endfunction

    localparam phase_e HPhaseRst = phase_last(H_FP, H_SYNC, H_BP);
    localparam phase_e VPhaseRst = phase_last(V_FP, V_SYNC, V_BP);

    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             x_wrap;
    phase_e           h_phase_q, h_phase_d;
    phase_e           v_phase_q, v_phase_d;

    logic hsync_q, vsync_q, de_q, vblank_q, line_start_q, frame_start_q;

    always_comb begin
        x_wrap    = (x_q == HLast);
        x_d       = x_wrap ? '0 : x_q + CNT_W'(1);
        y_d       = y_q;
        v_phase_d = v_phase_q;
        if (x_wrap) begin
            y_d       = (y_q == VLast) ? '0 : y_q + CNT_W'(1);
            v_phase_d = phase_step(y_d, v_phase_q, V_ACTIVE, V_FP, V_SYNC);
        end
        h_phase_d = phase_step(x_d, h_phase_q, H_ACTIVE, H_FP, H_SYNC);
    end

    // Controls are computed from the next position so they land on the same edge as x/y.
    always_ff @(posedge pix_clk) begin
        if (reset) begin
            x_q           <= HLast;
            y_q           <= VLast;
            h_phase_q     <= HPhaseRst;
            v_phase_q     <= VPhaseRst;
            hsync_q       <= ~H_SYNC_POL;
            vsync_q       <= ~V_SYNC_POL;
            de_q          <= 1'b0;
            vblank_q      <= VBlankRst;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (pix_en) begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_phase_q     <= h_phase_d;
            v_phase_q     <= v_phase_d;
            hsync_q       <= (h_phase_d == PhSync) ? H_SYNC_POL : ~H_SYNC_POL;
            vsync_q       <= (v_phase_d == PhSync) ? V_SYNC_POL : ~V_SYNC_POL;
            de_q          <= (h_phase_d == PhActive) && (v_phase_d == PhActive);
            vblank_q      <= (v_phase_d != PhActive);
            line_start_q  <= (x_d == '0);
            frame_start_q <= (x_d == '0) && (y_d == '0);
        end
    end

    assign x = x_q;
    assign y = y_q;

`ifdef VGA_TIMING_OUT_DLY_EN
    // Extra stage lines the controls up with a 1-cycle framebuffer read addressed by x/y.
    logic hsync_dq, vsync_dq, de_dq, vblank_dq, line_start_dq, frame_start_dq;

    always_ff @(posedge pix_clk) begin
        if (reset) begin
            hsync_dq       <= ~H_SYNC_POL;
            vsync_dq       <= ~V_SYNC_POL;
            de_dq          <= 1'b0;
            vblank_dq      <= VBlankRst;
            line_start_dq  <= 1'b0;
            frame_start_dq <= 1'b0;
        end else if (pix_en) begin
            hsync_dq       <= hsync_q;
            vsync_dq       <= vsync_q;
            de_dq          <= de_q;
            vblank_dq      <= vblank_q;
            line_start_dq  <= line_start_q;
            frame_start_dq <= frame_start_q;
        end
    end

    assign hsync       = hsync_dq;
    assign vsync       = vsync_dq;
    assign de          = de_dq;
    assign vblank      = vblank_dq;
    assign line_start  = line_start_dq;
    assign frame_start = frame_start_dq;
`else
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign vblank      = vblank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
`endif

`ifndef SYNTHESIS
    initial begin
        if (64'(H_TOTAL) > (64'd1 << CNT_W)) $error("vga_timing_gen: H_TOTAL exceeds 2^CNT_W");
        if (64'(V_TOTAL) > (64'd1 << CNT_W)) $error("vga_timing_gen: V_TOTAL exceeds 2^CNT_W");
        if (H_ACTIVE == 0) $error("vga_timing_gen: H_ACTIVE must be non-zero");
        if (V_ACTIVE == 0) $error("vga_timing_gen: V_ACTIVE must be non-zero");
    end
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Fully parametrised VGA/raster timing generator, successor to the fixed-640x480 controller.
- Produces hsync, vsync, data-enable, pixel coordinates and line/frame strobes from a single pixel clock with clock-enable, so one fast clock can drive slower pixel rates.
- Sits between the clock/reset block and the pixel source (framebuffer, pattern generator).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, hsync active level (0 = active-low)
- V_SYNC_POL, 0, vsync active level
- CNT_W, 10, counter width; H_TOTAL-1 and V_TOTAL-1 must fit

Ports:
- pix_clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  clock enable; timing advances only on cycles with pix_en=1
- hsync  out  1  horizontal sync at H_SYNC_POL level during the sync phase
- vsync  out  1  vertical sync at V_SYNC_POL level during the sync lines
- de  out  1  high when both axes are in the active phase
- x  out  CNT_W  horizontal counter, 0..H_TOTAL-1
- y  out  CNT_W  vertical counter, 0..V_TOTAL-1
- line_start  out  1  high while x==0
- frame_start  out  1  high while x==0 and y==0
- vblank  out  1  high while y>=V_ACTIVE

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800). V_TOTAL is defined the same way from the V_ parameters (default 525).
- Per-axis phase FSM with states ACTIVE -> FP -> SYNC -> BP -> ACTIVE. It is driven by the axis counter hitting each phase boundary.
- A zero-length phase is skipped.
- Horizontal phase boundaries:
  - ACTIVE for x in [0, H_ACTIVE)
  - FP for [H_ACTIVE, H_ACTIVE+H_FP)
  - SYNC for the next H_SYNC pixels
  - BP for the remainder
- Vertical phases have the same structure on y and change only when x wraps.
- On a pix_en=1 cycle:
  - x increments.
  - At x==H_TOTAL-1, x wraps to 0 and y increments.
  - At y==V_TOTAL-1 together with the x wrap, y wraps to 0.
- pix_en=0: all state and outputs hold.
- All outputs are registered and updated on the same edge as the counters, so x/y and hsync/vsync/de/strobes always describe the same position. There is zero combinational path from any input to any output.
- Reset state is the last position of the frame:
  - x=H_TOTAL-1, y=V_TOTAL-1
  - de=0, vblank=1 (when V_FP+V_SYNC+V_BP>0)
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL
  - line_start=0, frame_start=0
- First pix_en cycle after reset: x=0, y=0, de=1, line_start=1, frame_start=1.
- Reset mid-frame takes priority over pix_en and returns to the reset state on the next edge.
- Strobes are level-qualified by position, not single-cycle pulses. Consumers AND them with pix_en.
- Parameter check (sim only): an initial block issues $error if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if H_ACTIVE or V_ACTIVE is 0.

Optional Feature:
- Macro: VGA_TIMING_OUT_DLY_EN.
- Defined:
  - hsync, vsync, de, vblank, line_start and frame_start pass through one extra pix_en-qualified register stage. x and y are not delayed.
  - This aligns the control signals with a framebuffer read that has 1-cycle latency and is addressed by x/y.
  - Reset loads the delay stage with the same inactive values as the reset state.
- Undefined: no delay stage; controls are aligned with x/y as described above.

Test Plan:
- Defaults, pix_en=1, run 2 frames:
  - exactly 420000 cycles between frame_start rising edges
  - 307200 de-high cycles per frame
  - hsync low for x=656..751 (96 cycles) on every line
  - vsync low for y=490..491 inclusive, with edges at x==0
- Small params H 4/1/2/1, V 3/1/1/1, H_SYNC_POL=1:
  - per line: de=1,1,1,1,0,0,0,0
  - hsync=0,0,0,0,0,1,1,0
  - 48-cycle frame
- pix_en toggling 1,0,1,0: all outputs hold on pix_en=0 cycles and the frame period doubles to 840000 clocks.
- Reset asserted at x=300, y=200 for 3 clocks:
  - outputs equal the reset state during reset
  - first pix_en cycle after release gives x=0, y=0, frame_start=1
- V_FP=0, V_SYNC=2, V_BP=0 (zero-length phases): vsync asserts on the line immediately after y=V_ACTIVE-1 and the wrap is correct.
- VGA_TIMING_OUT_DLY_EN defined: de rises one pix_en cycle after x==0, y==0, and hsync edges lag x by one pix_en cycle.
